// File: rtl/axil_cfg_pkg.sv
// Shared constants for the AXI-Lite config write path.
// Holds response codes, bank selects, FSM encoding and register/field numbers.
package axil_cfg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BSEL_B0 = 2'b00;
  localparam logic [1:0] BSEL_B1 = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [7:0] F_SRC_ADDR = 8'd0;
  localparam logic [7:0] F_SRC_SIZE = 8'd1;
  localparam logic [7:0] F_DST_ADDR = 8'd2;
  localparam logic [7:0] F_DST_SIZE = 8'd3;
  localparam logic [7:0] F_STATUS   = 8'd4;
  localparam logic [7:0] F_PROFILE  = 8'd5;

  localparam logic [7:0] R_CONTROL  = 8'd0;
  localparam logic [7:0] R_END_CNT  = 8'd3;
  localparam logic [7:0] R_DMA_BASE = 8'd4;
  localparam logic [7:0] R_DFX_CTRL = 8'd5;

endpackage

// File: rtl/axil_cfg_addr_dec.sv
// Combinational address decode for the config write path.
// Splits an AXI-Lite address into bank, slot index, field and error.
module axil_cfg_addr_dec #(
  parameter int ADDR_WIDTH    = 16,
  parameter int NUM_SLOTS     = 8,
  parameter int IDX_W         = 3,
  parameter int BANK0_NREGS   = 6,
  parameter int BANK1_NFIELDS = 6
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  bank,
  output logic [IDX_W-1:0]      index,
  output logic [7:0]            field,
  output logic                  err
);
  import axil_cfg_pkg::*;

  localparam int SW = ADDR_WIDTH - 8;

  logic [1:0]    bsel;
  logic [SW-1:0] slot;
  logic [3:0]    fld;
  logic          mis;

  assign bsel = addr[ADDR_WIDTH-1:ADDR_WIDTH-2];
  assign slot = addr[ADDR_WIDTH-3:6];
  assign fld  = addr[5:2];
  assign mis  = (addr[1:0] != 2'b00);

  // Range checks use the full slot bits so aliased indices are rejected.
  always_comb begin
    bank  = 1'b0;
    index = '0;
    field = '0;
    err   = 1'b1;
    unique case (1'b1)
      (bsel == BSEL_B0): begin
        field = 8'(slot);
        err   = mis | (slot >= SW'(BANK0_NREGS));
      end
      (bsel == BSEL_B1): begin
        bank  = 1'b1;
        index = slot[IDX_W-1:0];
        field = {4'b0000, fld};
        err   = mis
              | (slot >= SW'(NUM_SLOTS))
              | (fld >= 4'(BANK1_NFIELDS));
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/axil_cfg_write.sv
// AXI-Lite write slave that turns writes into one-cycle config commits.
// Build option AXIL_CFG_STRB_CHECK_EN rejects partial-strobe writes.
module axil_cfg_write #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_SLOTS     = 8,
  parameter int IDX_W         = 3,
  parameter int BANK0_NREGS   = 6,
  parameter int BANK1_NFIELDS = 6,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  output logic                    cfg_wr_valid,
  output logic                    cfg_wr_bank,
  output logic [IDX_W-1:0]        cfg_wr_index,
  output logic [7:0]              cfg_wr_field,
  output logic [DATA_WIDTH-1:0]   cfg_wr_data,
  output logic [DATA_WIDTH/8-1:0] cfg_wr_strb,
  output logic [ERR_CNT_W-1:0]    err_cnt
);
  import axil_cfg_pkg::*;

  localparam int SB = DATA_WIDTH / 8;

  state_t                state;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [SB-1:0]         w_strb;
  logic                  cmt_err;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  go;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic [SB-1:0]         nxt_strb;
  logic                  dec_bank;
  logic [IDX_W-1:0]      dec_index;
  logic [7:0]            dec_field;
  logic                  dec_err;
  logic                  wr_err;

  assign S_AXI_AWREADY = (state == ST_IDLE) && !aw_held;
  assign S_AXI_WREADY  = (state == ST_IDLE) && !w_held;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign go    = (aw_held || aw_hs) && (w_held || w_hs);

  // Bypass the holding regs so a same-edge beat decodes without a bubble.
  assign nxt_addr = aw_held ? aw_addr : S_AXI_AWADDR;
  assign nxt_data = w_held ? w_data : S_AXI_WDATA;
  assign nxt_strb = w_held ? w_strb : S_AXI_WSTRB;

  axil_cfg_addr_dec #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .NUM_SLOTS     (NUM_SLOTS),
    .IDX_W         (IDX_W),
    .BANK0_NREGS   (BANK0_NREGS),
    .BANK1_NFIELDS (BANK1_NFIELDS)
  ) u_dec (
    .addr  (nxt_addr),
    .bank  (dec_bank),
    .index (dec_index),
    .field (dec_field),
    .err   (dec_err)
  );

`ifdef AXIL_CFG_STRB_CHECK_EN
  assign wr_err = dec_err | (nxt_strb != {SB{1'b1}});
`else
  assign wr_err = dec_err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr      <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      cmt_err      <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      cfg_wr_valid <= 1'b0;
      cfg_wr_bank  <= 1'b0;
      cfg_wr_index <= '0;
      cfg_wr_field <= '0;
      cfg_wr_data  <= '0;
      cfg_wr_strb  <= '0;
      err_cnt      <= '0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            state        <= ST_COMMIT;
            cmt_err      <= wr_err;
            cfg_wr_valid <= !wr_err;
            cfg_wr_bank  <= dec_bank;
            cfg_wr_index <= dec_index;
            cfg_wr_field <= dec_field;
            cfg_wr_data  <= nxt_data;
            cfg_wr_strb  <= nxt_strb;
          end
        end
        ST_COMMIT: begin
          state        <= ST_RESP;
          cfg_wr_valid <= 1'b0;
          S_AXI_BVALID <= 1'b1;
          S_AXI_BRESP  <= cmt_err ? RESP_SLVERR : RESP_OKAY;
          if (cmt_err && (err_cnt != {ERR_CNT_W{1'b1}}))
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
        ST_RESP: begin
          if (S_AXI_BREADY) begin
            state        <= ST_IDLE;
            S_AXI_BVALID <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cfg_write.sv
// Directed bench for axil_cfg_write.
// Hand-computed vectors for decode, ordering, errors, back-pressure, reset.
module tb_axil_cfg_write;
  import axil_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic        cfg_wr_valid;
  logic        cfg_wr_bank;
  logic [2:0]  cfg_wr_index;
  logic [7:0]  cfg_wr_field;
  logic [31:0] cfg_wr_data;
  logic [3:0]  cfg_wr_strb;
  logic [7:0]  err_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int pulse_cnt = 0;
  logic        last_bank;
  logic [2:0]  last_index;
  logic [7:0]  last_field;
  logic [31:0] last_data;
  logic [3:0]  last_strb;

  always #5 clk = ~clk;

  axil_cfg_write dut (
    .clk           (clk),
    .reset         (reset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .cfg_wr_valid  (cfg_wr_valid),
    .cfg_wr_bank   (cfg_wr_bank),
    .cfg_wr_index  (cfg_wr_index),
    .cfg_wr_field  (cfg_wr_field),
    .cfg_wr_data   (cfg_wr_data),
    .cfg_wr_strb   (cfg_wr_strb),
    .err_cnt       (err_cnt)
  );

  always @(negedge clk) begin
    if (cfg_wr_valid) begin
      pulse_cnt  <= pulse_cnt + 1;
      last_bank  <= cfg_wr_bank;
      last_index <= cfg_wr_index;
      last_field <= cfg_wr_field;
      last_data  <= cfg_wr_data;
      last_strb  <= cfg_wr_strb;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a,
                       input logic [31:0] d,
                       input logic [3:0]  s);
    bit aw_done = 0;
    bit w_done = 0;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      step();
      n++;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) chk("issue_timeout", 0, 1);
  endtask

  task automatic wait_resp(output logic [1:0] r);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 20) begin
      step();
      n++;
    end
    if (!bvalid) chk("resp_timeout", 0, 1);
    r = bresp;
    step();
  endtask

  task automatic wr(input logic [15:0] a,
                    input logic [31:0] d,
                    input logic [3:0]  s,
                    output logic [1:0] r);
    issue(a, d, s);
    wait_resp(r);
  endtask

  logic [1:0] r;
  int p0;
  logic [15:0] err_addr [5];

  initial begin
    err_addr[0] = 16'h8000;
    err_addr[1] = 16'h4002;
    err_addr[2] = 16'h4240;
    err_addr[3] = 16'h0180;
    err_addr[4] = 16'h4018;

    repeat (3) step();
    reset = 1'b0;
    chk("rst_awready", 32'(awready), 1);
    chk("rst_wready", 32'(wready), 1);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_errcnt", 32'(err_cnt), 0);
    chk("rst_pulse", 32'(cfg_wr_valid), 0);

    // same-cycle AW+W, bank1 slot 2 field 1
    bready = 1'b1;
    awaddr = 16'h4084; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("b1_valid", 32'(cfg_wr_valid), 1);
    chk("b1_bank", 32'(cfg_wr_bank), 1);
    chk("b1_index", 32'(cfg_wr_index), 2);
    chk("b1_field", 32'(cfg_wr_field), 32'(F_SRC_SIZE));
    chk("b1_data", cfg_wr_data, 32'hDEADBEEF);
    chk("b1_bvalid_early", 32'(bvalid), 0);
    chk("b1_awready_held", 32'(awready), 0);
    step();
    chk("b1_pulse_end", 32'(cfg_wr_valid), 0);
    chk("b1_bvalid", 32'(bvalid), 1);
    chk("b1_bresp", 32'(bresp), 0);
    step();
    chk("b1_bdone", 32'(bvalid), 0);
    chk("b1_awready_back", 32'(awready), 1);
    chk("b1_pulses", pulse_cnt, 1);

    // W three cycles ahead of AW
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    chk("wfirst_wready0", 32'(wready), 1);
    step();
    wvalid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("wfirst_wready_c%0d", i), 32'(wready), 0);
      if (i == 3) begin
        awaddr = 16'h0100;
        awvalid = 1'b1;
      end
      step();
    end
    awvalid = 1'b0;
    chk("wfirst_valid", 32'(cfg_wr_valid), 1);
    chk("wfirst_bank", 32'(cfg_wr_bank), 0);
    chk("wfirst_field", 32'(cfg_wr_field), 32'(R_DMA_BASE));
    chk("wfirst_index", 32'(cfg_wr_index), 0);
    chk("wfirst_data", cfg_wr_data, 32'hCAFEF00D);
    wait_resp(r);
    chk("wfirst_bresp", 32'(r), 0);

    // decode errors
    p0 = pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      wr(err_addr[i], 32'h1111_0000 + 32'(i), 4'hF, r);
      chk($sformatf("err_bresp_%0d", i), 32'(r), 2);
    end
    chk("err_cnt3", 32'(err_cnt), 3);
    for (int i = 3; i < 5; i++) begin
      wr(err_addr[i], 32'h2222_0000, 4'hF, r);
      chk($sformatf("err_bresp_%0d", i), 32'(r), 2);
    end
    chk("err_cnt5", 32'(err_cnt), 5);
    chk("err_no_pulse", pulse_cnt, p0);

    // held response under BREADY low
    bready = 1'b0;
    issue(16'h40C8, 32'h12345678, 4'hF);
    for (int n = 0; n < 5 && !bvalid; n++) step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_bvalid_%0d", i), 32'(bvalid), 1);
      chk($sformatf("bp_bresp_%0d", i), 32'(bresp), 0);
      chk($sformatf("bp_rdy_%0d", i), 32'({awready, wready}), 0);
      step();
    end
    bready = 1'b1;
    chk("bp_last_bvalid", 32'(bvalid), 1);
    step();
    chk("bp_done", 32'(bvalid), 0);
    chk("bp_awready", 32'(awready), 1);
    chk("bp_index", 32'(last_index), 3);
    chk("bp_field", 32'(last_field), 32'(F_DST_ADDR));
    chk("bp_data", last_data, 32'h12345678);

    // reset while a response is pending
    bready = 1'b0;
    issue(16'hC000, 32'h0, 4'hF);
    for (int n = 0; n < 5 && !bvalid; n++) step();
    chk("rr_in_resp", 32'(bvalid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_bvalid", 32'(bvalid), 0);
    chk("rr_errcnt", 32'(err_cnt), 0);
    chk("rr_awready", 32'(awready), 1);
    p0 = pulse_cnt;
    wr(16'h0140, 32'hA5A5A5A5, 4'hF, r);
    chk("rr_bresp", 32'(r), 0);
    chk("rr_pulse", pulse_cnt, p0 + 1);
    chk("rr_field", 32'(last_field), 32'(R_DFX_CTRL));

    // partial strobes
    p0 = pulse_cnt;
    wr(16'h00C0, 32'h0000BEEF, 4'h3, r);
`ifdef AXIL_CFG_STRB_CHECK_EN
    chk("strb_bresp", 32'(r), 2);
    chk("strb_pulse", pulse_cnt, p0);
    chk("strb_errcnt", 32'(err_cnt), 1);
`else
    chk("strb_bresp", 32'(r), 0);
    chk("strb_pulse", pulse_cnt, p0 + 1);
    chk("strb_fwd", 32'(last_strb), 3);
    chk("strb_field", 32'(last_field), 32'(R_END_CNT));
`endif

    // err_cnt saturation
    for (int i = 0; i < 260; i++) wr(16'h8004, 32'h0, 4'hF, r);
    chk("sat_errcnt", 32'(err_cnt), 255);
    chk("sat_bresp", 32'(r), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
